// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS32 DIV/DIVU sequencer: default widths,
// sequencer states and the conditional two's complement helper.
package mdu_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 5;   // clog2(DIV_WIDTH)

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_e;

    // Negate modulo 2^DIV_WIDTH when neg is set. This yields |x| for a negative
    // operand and applies the result signs after the unsigned core.
    function automatic logic [DIV_WIDTH-1:0] cond_neg(
        input logic [DIV_WIDTH-1:0] value,
        input logic                 neg
    );
        return neg ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and trial-subtract the divisor. This holds the only subtractor in
// the divider.
module mdu_div_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // The partial remainder is always below the divisor. The trial value is
    // therefore below 2*divisor, and WIDTH+1 bits hold the difference with a
    // correct sign bit.
    assign trial   = {rem_i, dvd_bit_i};
    assign diff    = trial - {1'b0, dvs_i};
    assign q_bit_o = ~diff[WIDTH];
    assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/mdu_div_seq.sv
// Multi-cycle MIPS32 DIV/DIVU sequencer. It owns the HI (remainder) and
// LO (quotient) registers and drives a one-bit-per-cycle restoring divider.
// Sequence: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> DONE -> IDLE.
// done_o is a registered pulse in the cycle after DONE. start_i is not
// accepted in that cycle.
//
// Optional build macro MDU_DIV_EARLY_ZERO_EN: a zero divisor skips the
// iteration and goes straight from PREP to DONE. lo is all ones and hi is the
// dividend. Without the macro, a zero divisor runs the full iteration.
module mdu_div_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvd_q;        // dividend; quotient bits shift in at the LSB
    logic [WIDTH-1:0] dvs_q;        // divisor (raw in PREP, magnitude afterwards)
    logic [WIDTH-1:0] rem_q;        // partial remainder
    logic             signed_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             dbz_pend_q;   // zero divisor seen in PREP, published in FIX
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             div_by_zero_q;

    logic [WIDTH-1:0] rem_d;
    logic             q_bit_d;
    logic             a_neg;
    logic             b_neg;

    assign a_neg = signed_q & dvd_q[WIDTH-1];
    assign b_neg = signed_q & dvs_q[WIDTH-1];

    mdu_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (rem_d),
        .q_bit_o   (q_bit_d)
    );

    // Sequencer FSM. All working and result registers are updated here.
    // NOTE: every register in this block is assigned with <=. All of them
    // then sample the same pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dvd_q         <= '0;
            dvs_q         <= '0;
            rem_q         <= '0;
            signed_q      <= 1'b0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dbz_pend_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Starts are ignored during the done pulse. A request
                    // held across completion cannot re-issue immediately.
                    if (start_i && !done_q) begin
                        dvd_q    <= a_i;
                        dvs_q    <= b_i;
                        signed_q <= is_signed_i;
                        busy_q   <= 1'b1;
                        state_q  <= PREP;
                    end
                end

                PREP: begin
                    if (flush_i) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        q_neg_q    <= a_neg ^ b_neg;
                        r_neg_q    <= a_neg;
                        dvd_q      <= cond_neg(dvd_q, a_neg);
                        dvs_q      <= cond_neg(dvs_q, b_neg);
                        rem_q      <= '0;
                        cnt_q      <= CNT_W'(WIDTH - 1);
                        dbz_pend_q <= (dvs_q == '0);
`ifdef MDU_DIV_EARLY_ZERO_EN
                        if (dvs_q == '0) begin
                            hi_q          <= dvd_q;
                            lo_q          <= '1;
                            div_by_zero_q <= 1'b1;
                            state_q       <= DONE;
                        end else begin
                            state_q <= ITER;
                        end
`else
                        state_q    <= ITER;
`endif
                    end
                end

                ITER: begin
                    if (flush_i) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= {dvd_q[WIDTH-2:0], q_bit_d};
                        if (cnt_q == '0) begin
                            state_q <= FIX;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end

                FIX: begin
                    if (flush_i) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        hi_q          <= cond_neg(rem_q, r_neg_q);
                        lo_q          <= cond_neg(dvd_q, q_neg_q);
                        div_by_zero_q <= dbz_pend_q;
                        state_q       <= DONE;
                    end
                end

                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign div_by_zero_o = div_by_zero_q;

endmodule

// File: tb/tb_mdu_div_seq.sv
// Self-checking bench for mdu_div_seq. Directed cases cover signed/unsigned
// results, overflow, divide by zero, flush, held start and async reset.
// Randomized operands follow. Expected results come from integer arithmetic
// on the operands.
module tb_mdu_div_seq;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        is_signed_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_by_zero_o;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] last_hi  = '0;
    logic [31:0] last_lo  = '0;
    logic        last_dbz = 1'b0;

    mdu_div_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .is_signed_i   (is_signed_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .flush_i       (flush_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .div_by_zero_o (div_by_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // MIPS DIV/DIVU reference: truncating division, remainder takes the dividend sign.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            hi = a;
            lo = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
`ifdef MDU_DIV_EARLY_ZERO_EN
            lo = 32'hFFFF_FFFF;
`endif
        end else if (!sgn) begin
            lo = a / b;
            hi = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endfunction

    function automatic int model_latency(input logic [31:0] b);
        int lat;
        lat = 35;
`ifdef MDU_DIV_EARLY_ZERO_EN
        if (b == 32'd0) lat = 2;
`endif
        return lat;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = $urandom;
            1:       v = $urandom_range(0, 20);
            2:       v = 32'h8000_0000;
            3:       v = 32'hFFFF_FFFF;
            4:       v = 32'd0 - $urandom_range(1, 20);
            default: v = $urandom >> $urandom_range(0, 31);
        endcase
        return v;
    endfunction

    // Present one start for a single cycle. Return just after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic with_flush);
        @(negedge clk);
        a_i         = a;
        b_i         = b;
        is_signed_i = sgn;
        start_i     = 1'b1;
        flush_i     = with_flush;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
    endtask

    // Follow an accepted operation to its done pulse and check the result.
    // flush_at=k raises flush during cycle k-1 (sampled at edge k).
    task automatic wait_done(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic sgn, input int flush_at);
        logic [31:0] ehi, elo;
        int          lat;
        logic        busy_ok;
        model(a, b, sgn, ehi, elo);
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            flush_i = (k == flush_at);
            @(posedge clk);
            #1;
            flush_i = 1'b0;
            if (done_o) begin
                lat = k;
                break;
            end
            if (!busy_o) busy_ok = 1'b0;
        end
        check({tag, " latency"}, 64'(lat), 64'(model_latency(b)));
        check({tag, " busy"}, 64'(busy_ok), 64'd1);
        check({tag, " busy at done"}, 64'(busy_o), 64'd0);
        check({tag, " lo"}, 64'(lo_o), 64'(elo));
        check({tag, " hi"}, 64'(hi_o), 64'(ehi));
        check({tag, " dbz"}, 64'(div_by_zero_o), 64'(b == 32'd0));
        last_hi  = ehi;
        last_lo  = elo;
        last_dbz = (b == 32'd0);
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, 64'({busy_o, done_o}), 64'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn);
        issue(a, b, sgn, 1'b0);
        wait_done(tag, a, b, sgn, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        saw_done;
        logic [31:0] ra, rb;
        logic        rs, rf;
        int          fa;

        rst_n       = 1'b0;
        start_i     = 1'b0;
        is_signed_i = 1'b0;
        a_i         = '0;
        b_i         = '0;
        flush_i     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset done", 64'(done_o), 64'd0);
        check("reset hi", 64'(hi_o), 64'd0);
        check("reset lo", 64'(lo_o), 64'd0);
        check("reset dbz", 64'(div_by_zero_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic and signed cases, overflow, divide by zero.
        run("u100/7", 32'd100, 32'd7, 1'b0);
        run("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        run("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        run("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run("u ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run("s div0", 32'hFFFF_FFF0, 32'd0, 1'b1);
        run("u div0", 32'hFFFF_FFF0, 32'd0, 1'b0);

        // flush in PREP/ITER/FIX aborts with no done; results unchanged.
        issue(32'd100, 32'd7, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush busy", 64'(busy_o), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o) saw_done = 1'b1;
        end
        check("flush no done", 64'(saw_done), 64'd0);
        check("flush hi kept", 64'(hi_o), 64'(last_hi));
        check("flush lo kept", 64'(lo_o), 64'(last_lo));
        check("flush dbz kept", 64'(div_by_zero_o), 64'(last_dbz));
        run("after flush", 32'd1000, 32'd33, 1'b0);

        // flush in PREP: the abort happens one edge after acceptance.
        issue(32'd55, 32'd5, 1'b0, 1'b0);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("prep flush busy", 64'(busy_o), 64'd0);

        // flush together with start in IDLE: start wins. flush during DONE is ignored.
        issue(32'hDEAD_BEEF, 32'd77, 1'b1, 1'b1);
        wait_done("idle flush", 32'hDEAD_BEEF, 32'd77, 1'b1, 0);
        issue(32'd12345, 32'd67, 1'b0, 1'b0);
        wait_done("done flush", 32'd12345, 32'd67, 1'b0, 35);

        // start held high throughout: later operands are ignored; no re-issue after done.
        @(negedge clk);
        a_i         = 32'd100;
        b_i         = 32'd7;
        is_signed_i = 1'b0;
        start_i     = 1'b1;
        @(posedge clk);
        #1;
        a_i = 32'd999;
        b_i = 32'd3;
        wait_done("held start", 32'd100, 32'd7, 1'b0, 0);
        start_i = 1'b0;

        // Async reset mid-operation clears everything at once; no done follows.
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        repeat (14) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst busy", 64'(busy_o), 64'd0);
        check("async rst done", 64'(done_o), 64'd0);
        check("async rst hi", 64'(hi_o), 64'd0);
        check("async rst lo", 64'(lo_o), 64'd0);
        check("async rst dbz", 64'(div_by_zero_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o) saw_done = 1'b1;
        end
        check("rst no done", 64'(saw_done), 64'd0);
        run("after rst", 32'd100, 32'd7, 1'b0);

        // Randomized operands with occasional start+flush or flush during DONE.
        for (int i = 0; i < 30; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            rs = 1'($urandom_range(0, 1));
            rf = ($urandom_range(0, 5) == 0);
            fa = ($urandom_range(0, 4) == 0 && rb != 32'd0) ? 35 : 0;
            issue(ra, rb, rs, rf);
            wait_done($sformatf("rnd%0d %h/%h s%0d", i, ra, rb, rs), ra, rb, rs, fa);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
